cell_dequeue_engine: RTL

- Parametrised read-side engine for the shared-buffer switch.
- Arbitrates among NPORT per-port descriptor queues, honouring per-port output back-pressure.
- Streams each granted cell out of the shared data SRAM as CELL_BEATS beats.
- Decrements the multicast reference count and returns the buffer pointer to the free queue when the last copy is read.
- Compared with the current fixed 4-port read path it adds: port count, width and latency generics, selectable arbitration mode, true round-robin fairness, and refcount underflow detection.

---
 rtl/switch_pkg.sv | 31 +++
 rtl/sw_rr_arbiter.sv | 61 ++++++
 rtl/cell_dequeue_engine.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// Shared definitions for the shared-buffer switch read path.
//   - descriptor field positions (ptr in the low bits, then first, then last)
//   - arbitration mode constants
//   - dequeue FSM state encoding
//   - refcount width helper
package switch_pkg;

    localparam int ARB_RR     = 0;
    localparam int ARB_STRICT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        REL  = 2'd2
    } dq_state_t;

    // Descriptor layout: {last, first, ptr}
    function automatic int first_bit(input int ptr_w);
        return ptr_w;
    endfunction

    function automatic int last_bit(input int ptr_w);
        return ptr_w + 1;
    endfunction

    // Refcount must hold a value up to the port count.
    function automatic int cnt_width(input int nport);
        return $clog2(nport + 1);
    endfunction

endpackage

// File: rtl/sw_rr_arbiter.sv
// One-hot arbiter over NPORT requesters.
//   clk, rstn  : clock, async active-low reset
//   req        : request vector
//   grant_en   : a grant taken this cycle is committed (advances rr_ptr)
//   grant      : one-hot grant, combinational from req
// ARB_MODE selects round-robin (search from rr_ptr, wrapping) or strict
// priority (port 0 highest). rr_ptr moves to one past the winner only when a
// grant is actually committed.
module sw_rr_arbiter
    import switch_pkg::*;
#(
    parameter int NPORT    = 4,
    parameter int ARB_MODE = ARB_RR
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic [NPORT-1:0] req,
    input  logic             grant_en,
    output logic [NPORT-1:0] grant
);

    localparam int PW = $clog2(NPORT);

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      base;
    logic [PW-1:0]      off;
    logic [PW-1:0]      gidx;
    logic [PW:0]        sum;
    logic [2*NPORT-1:0] rot;
    logic [NPORT-1:0]   rot_lo;
    logic               found;

    // Rotate the request vector so the search start lands on bit 0, pick the
    // lowest set bit, then rotate the index back (mod NPORT).
    always_comb begin
        base   = (ARB_MODE == ARB_STRICT) ? '0 : rr_ptr;
        rot    = {req, req} >> base;
        rot_lo = rot[NPORT-1:0];
        found  = 1'b0;
        off    = '0;
        for (int j = NPORT - 1; j >= 0; j--) begin
            if (rot_lo[j]) begin
                found = 1'b1;
                off   = PW'(j);
            end
        end
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (PW+1)'(NPORT))
            sum = sum - (PW+1)'(NPORT);
        gidx  = sum[PW-1:0];
        grant = found ? (NPORT'(1) << gidx) : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            rr_ptr <= '0;
        else if (grant_en && found && (ARB_MODE == ARB_RR))
            rr_ptr <= (gidx == PW'(NPORT - 1)) ? '0 : gidx + 1'b1;
    end

endmodule

// File: rtl/cell_dequeue_engine.sv
// Read-side engine of the shared-buffer switch.
//   clk, rstn        : clock, async active-low reset
//   q_rdy, q_desc    : per-queue descriptor valid / {last, first, ptr}
//   q_ack            : one-hot pop pulse for the granted queue
//   o_bp             : per-port output back-pressure (checked at grant only)
//   ram_rd_*         : data SRAM read port, {ptr, beat} addressing
//   mc_*             : refcount RAM read address / write-back
//   fq_wr, fq_din    : free-pointer return
//   o_wr, o_sel, o_data, o_first, o_last : output beat stream
//   err_refcnt       : sticky refcount underflow
//
// state | meaning
// IDLE  | wait for an eligible queue, register the grant and descriptor
// READ  | CELL_BEATS cycles of data reads; first cycle pops the queue
// REL   | refcount read-modify-write, free the pointer on the last copy
module cell_dequeue_engine
    import switch_pkg::*;
#(
    parameter int NPORT      = 4,
    parameter int DW         = 128,
    parameter int PTR_W      = 10,
    parameter int CELL_BEATS = 4,
    parameter int RAM_LAT    = 2,
    parameter int ARB_MODE   = ARB_RR,
    parameter int CNT_W      = cnt_width(NPORT)
)(
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [NPORT-1:0]                      q_rdy,
    input  logic [NPORT*(PTR_W+2)-1:0]            q_desc,
    output logic [NPORT-1:0]                      q_ack,
    input  logic [NPORT-1:0]                      o_bp,
    output logic                                  ram_rd_en,
    output logic [PTR_W+$clog2(CELL_BEATS)-1:0]   ram_rd_addr,
    input  logic [DW-1:0]                         ram_rd_data,
    output logic [PTR_W-1:0]                      mc_addr,
    input  logic [CNT_W-1:0]                      mc_rdata,
    output logic                                  mc_we,
    output logic [CNT_W-1:0]                      mc_wdata,
    output logic                                  fq_wr,
    output logic [PTR_W-1:0]                      fq_din,
    output logic                                  o_wr,
    output logic [NPORT-1:0]                      o_sel,
    output logic [DW-1:0]                         o_data,
    output logic                                  o_first,
    output logic                                  o_last,
    output logic                                  err_refcnt
);

    localparam int BW        = $clog2(CELL_BEATS);
    localparam int DESC_W    = PTR_W + 2;
    localparam int FIRST_BIT = first_bit(PTR_W);
    localparam int LAST_BIT  = last_bit(PTR_W);

    dq_state_t          state, state_nxt;
    logic [NPORT-1:0]   elig;
    logic [NPORT-1:0]   grant;
    logic [NPORT-1:0]   sel_q;
    logic [DESC_W-1:0]  gdesc;
    logic [PTR_W-1:0]   ptr_q;
    logic               first_q;
    logic               last_q;
    logic [BW-1:0]      beat_q;
    logic               last_beat;
    logic               grant_en;
    logic               take;

    logic               dl_valid [RAM_LAT];
    logic [NPORT-1:0]   dl_sel   [RAM_LAT];
    logic               dl_first [RAM_LAT];
    logic               dl_last  [RAM_LAT];

    assign elig      = q_rdy & ~o_bp;
    assign grant_en  = (state == IDLE);
    assign take      = grant_en && (elig != '0);
    assign last_beat = (beat_q == BW'(CELL_BEATS - 1));

    sw_rr_arbiter #(
        .NPORT    (NPORT),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk      (clk),
        .rstn     (rstn),
        .req      (elig),
        .grant_en (grant_en),
        .grant    (grant)
    );

    always_comb begin
        gdesc = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant[i])
                gdesc = q_desc[i*DESC_W +: DESC_W];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (elig != '0) state_nxt = READ;
            READ:    if (last_beat)  state_nxt = REL;
            REL:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        q_ack       = '0;
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        mc_addr     = '0;
        mc_we       = 1'b0;
        mc_wdata    = '0;
        fq_wr       = 1'b0;
        fq_din      = '0;
        case (state)
            READ: begin
                ram_rd_en   = 1'b1;
                ram_rd_addr = {ptr_q, beat_q};
                mc_addr     = ptr_q;
                if (beat_q == '0)
                    q_ack = sel_q;
            end
            REL: begin
                mc_addr = ptr_q;
                mc_we   = 1'b1;
                if (mc_rdata == CNT_W'(1)) begin
                    fq_wr  = 1'b1;
                    fq_din = ptr_q;
                end else if (mc_rdata != '0) begin
                    mc_wdata = mc_rdata - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_q      <= '0;
            ptr_q      <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            beat_q     <= '0;
            err_refcnt <= 1'b0;
        end else begin
            if (take) begin
                sel_q   <= grant;
                ptr_q   <= gdesc[PTR_W-1:0];
                first_q <= gdesc[FIRST_BIT];
                last_q  <= gdesc[LAST_BIT];
            end
            if (state == READ)
                beat_q <= last_beat ? '0 : beat_q + 1'b1;
            else
                beat_q <= '0;
            if ((state == REL) && (mc_rdata == '0))
                err_refcnt <= 1'b1;
        end
    end

    // Beat attributes travel alongside the RAM read so they line up with
    // ram_rd_data; sel is zeroed on idle slots so it never goes stale.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < RAM_LAT; k++) begin
                dl_valid[k] <= 1'b0;
                dl_sel[k]   <= '0;
                dl_first[k] <= 1'b0;
                dl_last[k]  <= 1'b0;
            end
        end else begin
            dl_valid[0] <= ram_rd_en;
            dl_sel[0]   <= ram_rd_en ? sel_q : '0;
            dl_first[0] <= ram_rd_en && (beat_q == '0) && first_q;
            dl_last[0]  <= ram_rd_en && last_beat && last_q;
            for (int k = 1; k < RAM_LAT; k++) begin
                dl_valid[k] <= dl_valid[k-1];
                dl_sel[k]   <= dl_sel[k-1];
                dl_first[k] <= dl_first[k-1];
                dl_last[k]  <= dl_last[k-1];
            end
        end
    end

    assign o_wr    = dl_valid[RAM_LAT-1];
    assign o_sel   = dl_sel[RAM_LAT-1];
    assign o_first = dl_first[RAM_LAT-1];
    assign o_last  = dl_last[RAM_LAT-1];
    assign o_data  = o_wr ? ram_rd_data : '0;

endmodule
